// File: rtl/sva_latency_tracker_pkg.sv
// Shared types, default sizing and the saturating age increment for the latency tracker.
package sva_tracker_pkg;

    localparam int TRK_DEPTH   = 4;
    localparam int TRK_MAX_LAT = 3;
    localparam int TRK_LAT_W   = 4;

    // The age counter must be able to represent MAX_LAT+1 without saturating.
    localparam bit LAT_CFG_OK = ((2 ** TRK_LAT_W) - 1) > TRK_MAX_LAT;

    typedef logic [TRK_LAT_W-1:0] age_t;

    typedef struct packed {
        logic valid;
        age_t age;
    } entry_t;

    function automatic age_t sat_inc(input age_t a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/sva_latency_tracker_if.sv
// Request/response handshake plus the tracker's status and statistics outputs.
interface sva_latency_tracker_if #(
    parameter int DEPTH = 4,
    parameter int LAT_W = 4
);
    logic                   req;
    logic                   ack;
    logic                   clear;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   lat_valid;
    logic [LAT_W-1:0]       last_lat;
    logic [LAT_W-1:0]       max_lat;
    logic                   err_overflow;
    logic                   err_underflow;
    logic                   err_timeout;

    modport master (
        output req, ack, clear,
        input  outstanding, lat_valid, last_lat, max_lat,
               err_overflow, err_underflow, err_timeout
    );

    modport slave (
        input  req, ack, clear,
        output outstanding, lat_valid, last_lat, max_lat,
               err_overflow, err_underflow, err_timeout
    );
endinterface

// File: rtl/sva_latency_tracker_age_fifo.sv
// FIFO of outstanding requests; each entry carries an age that increments every cycle it waits.
module sva_age_fifo
    import sva_tracker_pkg::*;
#(
    parameter int DEPTH = TRK_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    output age_t                   head_age,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{valid: 1'b0, age: '0};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].valid) begin
                    mem[i].age <= sat_inc(mem[i].age);
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            // On a full push+pop both pointers address the same slot; the push is later and wins.
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, age: age_t'(1)};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_age = mem[rd_ptr].age;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/sva_latency_tracker.sv
// Matches req pulses to later ack pulses in FIFO order, reports latency and sticky error flags.
module sva_latency_tracker
    import sva_tracker_pkg::*;
#(
    parameter int DEPTH   = TRK_DEPTH,
    parameter int MAX_LAT = TRK_MAX_LAT,
    parameter int LAT_W   = TRK_LAT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sva_latency_tracker_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    age_t             head_age;
    logic [CW-1:0]    count;

    logic             lat_valid_q;
    logic [LAT_W-1:0] last_lat_q;
    logic [LAT_W-1:0] max_lat_q;
    logic             err_ovf_q;
    logic             err_udf_q;
    logic             err_to_q;

    assign push = bus.req && (!full || bus.ack);
    assign pop  = bus.ack && !empty;

    sva_age_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .head_age (head_age),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_valid_q <= 1'b0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            lat_valid_q <= pop;
            if (pop) begin
                last_lat_q <= head_age;
            end
            // clear outranks any error or statistic update arriving in the same cycle
            if (bus.clear) begin
                max_lat_q <= '0;
                err_ovf_q <= 1'b0;
                err_udf_q <= 1'b0;
                err_to_q  <= 1'b0;
            end else begin
                if (pop && (head_age > max_lat_q)) begin
                    max_lat_q <= head_age;
                end
                if (bus.req && full && !bus.ack) begin
                    err_ovf_q <= 1'b1;
                end
                if (bus.ack && empty) begin
                    err_udf_q <= 1'b1;
                end
                if (!empty && (head_age > age_t'(MAX_LAT)) && !bus.ack) begin
                    err_to_q <= 1'b1;
                end
            end
        end
    end

    assign bus.outstanding   = count;
    assign bus.lat_valid     = lat_valid_q;
    assign bus.last_lat      = last_lat_q;
    assign bus.max_lat       = max_lat_q;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_udf_q;
    assign bus.err_timeout   = err_to_q;

`ifdef FORMAL
    // Properties for the formal flow; directed simulation deliberately breaks the environment assumptions.
    am_no_ovf: assume property (@(posedge clk) disable iff (!reset_n) !(bus.req && full && !bus.ack));
    am_no_udf: assume property (@(posedge clk) disable iff (!reset_n) !(bus.ack && empty));
    as_cfg:    assert property (@(posedge clk) disable iff (!reset_n) LAT_CFG_OK);
    as_no_ovf: assert property (@(posedge clk) disable iff (!reset_n) !$rose(err_ovf_q));
    as_no_udf: assert property (@(posedge clk) disable iff (!reset_n) !$rose(err_udf_q));
    as_ack_in_time: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.req && (count == '0)) |-> ##[1:MAX_LAT] bus.ack);
`ifdef FAIL
    as_ack_needs_req: assert property (@(posedge clk) disable iff (!reset_n) bus.ack |-> bus.req);
`endif
`endif

endmodule

// File: tb/tb_sva_latency_tracker.sv
// Directed bench for sva_latency_tracker: latency, full/empty corners, timeout, clear and reset.
module tb_sva_latency_tracker;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    sva_latency_tracker_if #(.DEPTH(4), .LAT_W(4)) bus ();

    sva_latency_tracker #(.DEPTH(4), .MAX_LAT(3), .LAT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic a, input logic c);
        bus.req   = r;
        bus.ack   = a;
        bus.clear = c;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outstanding"}, 32'(bus.outstanding), 0);
        check({tag, ".lat_valid"},   32'(bus.lat_valid), 0);
        check({tag, ".last_lat"},    32'(bus.last_lat), 0);
        check({tag, ".max_lat"},     32'(bus.max_lat), 0);
        check({tag, ".err_ovf"},     32'(bus.err_overflow), 0);
        check({tag, ".err_udf"},     32'(bus.err_underflow), 0);
        check({tag, ".err_to"},      32'(bus.err_timeout), 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(0, 0, 0);
        cyc();
        cyc();
        check_all_zero("reset");
        reset_n = 1'b1;

        // single pair, latency 2
        drive(1, 0, 0); cyc();
        check("t1.outstanding", 32'(bus.outstanding), 1);
        drive(0, 0, 0); cyc();
        drive(0, 1, 0); cyc();
        check("t1.lat_valid", 32'(bus.lat_valid), 1);
        check("t1.last_lat",  32'(bus.last_lat), 2);
        check("t1.max_lat",   32'(bus.max_lat), 2);
        check("t1.outstanding_after", 32'(bus.outstanding), 0);
        check("t1.err_to", 32'(bus.err_timeout), 0);
        drive(0, 0, 0); cyc();
        check("t1.lat_valid_pulse", 32'(bus.lat_valid), 0);

        // pipelined reqs each acked one cycle later
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, i >= 1, 0);
            cyc();
            check($sformatf("t2.outstanding[%0d]", i), 32'(bus.outstanding), (i < 4) ? 1 : 0);
            check($sformatf("t2.lat_valid[%0d]", i), 32'(bus.lat_valid), (i >= 1) ? 1 : 0);
            if (i >= 1) check($sformatf("t2.last_lat[%0d]", i), 32'(bus.last_lat), 1);
        end
        drive(0, 0, 0);
        check("t2.max_lat", 32'(bus.max_lat), 2);

        // fill, overflow (head also times out), clear, then full push+pop
        drive(1, 0, 0);
        for (int i = 0; i < 4; i++) cyc();
        check("t3.full", 32'(bus.outstanding), 4);
        check("t3.no_to_yet", 32'(bus.err_timeout), 0);
        cyc();
        check("t3.err_ovf", 32'(bus.err_overflow), 1);
        check("t3.ovf_occ", 32'(bus.outstanding), 4);
        check("t3.err_to", 32'(bus.err_timeout), 1);
        drive(0, 0, 1); cyc();
        check("t3.clr_ovf", 32'(bus.err_overflow), 0);
        check("t3.clr_to_prio", 32'(bus.err_timeout), 0);
        check("t3.clr_max", 32'(bus.max_lat), 0);
        check("t3.clr_occ", 32'(bus.outstanding), 4);
        drive(1, 1, 0); cyc();
        check("t3.pp_occ", 32'(bus.outstanding), 4);
        check("t3.pp_ovf", 32'(bus.err_overflow), 0);
        check("t3.pp_to", 32'(bus.err_timeout), 0);
        check("t3.pp_last", 32'(bus.last_lat), 6);
        check("t3.pp_max", 32'(bus.max_lat), 6);
        drive(0, 1, 0);
        for (int i = 0; i < 4; i++) cyc();
        check("t3.drain_occ", 32'(bus.outstanding), 0);
        check("t3.drain_last", 32'(bus.last_lat), 4);
        check("t3.drain_max", 32'(bus.max_lat), 6);
        check("t3.drain_to", 32'(bus.err_timeout), 0);
        check("t3.drain_udf", 32'(bus.err_underflow), 0);

        // underflow with a same-cycle req that is still accepted
        drive(1, 1, 0); cyc();
        check("t4.err_udf", 32'(bus.err_underflow), 1);
        check("t4.occ", 32'(bus.outstanding), 1);
        check("t4.lat_valid", 32'(bus.lat_valid), 0);
        drive(0, 1, 0); cyc();
        check("t4.last_lat", 32'(bus.last_lat), 1);
        check("t4.udf_sticky", 32'(bus.err_underflow), 1);
        drive(0, 0, 1); cyc();
        check("t4.clr_udf", 32'(bus.err_underflow), 0);
        check("t4.clr_max", 32'(bus.max_lat), 0);

        // timeout: ack five cycles after req
        drive(1, 0, 0); cyc();
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc();
        check("t5.no_to_at_age4", 32'(bus.err_timeout), 0);
        cyc();
        check("t5.err_to", 32'(bus.err_timeout), 1);
        drive(0, 1, 0); cyc();
        check("t5.lat_valid", 32'(bus.lat_valid), 1);
        check("t5.last_lat", 32'(bus.last_lat), 5);
        check("t5.max_lat", 32'(bus.max_lat), 5);
        check("t5.occ", 32'(bus.outstanding), 0);
        drive(0, 0, 0);

        // asynchronous reset with two entries pending
        drive(1, 0, 0); cyc(); cyc();
        drive(0, 0, 0);
        check("t6.occ", 32'(bus.outstanding), 2);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6.async");
        #2;
        reset_n = 1'b1;
        drive(1, 0, 0); cyc();
        drive(0, 1, 0); cyc();
        check("t6.last_lat", 32'(bus.last_lat), 1);
        check("t6.max_lat", 32'(bus.max_lat), 1);
        check("t6.occ_after", 32'(bus.outstanding), 0);
        check("t6.err_to", 32'(bus.err_timeout), 0);
        check("t6.err_udf", 32'(bus.err_underflow), 0);
        drive(0, 0, 0); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
